mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on posedge clk.
REQ-002 SHALL: reset  in  1  synchronous, active-high reset; sampled on posedge clk only.
REQ-003 SHALL: RegWrite_n  in  1  EX/MEM register-write enable.
REQ-004 SHALL: link_pc_n  in  16  EX/MEM link PC.
REQ-005 SHALL: mem_read_n / mem_write_n  in  1 each  EX/MEM data-memory read/write request.
REQ-006 SHALL: write_back_n  in  2  write-back select; 00 ALU, 01 memory, 10 shifter, 11 link PC.
REQ-007 SHALL: ALU_output_n  in  16  ALU result and memory address.
REQ-008 SHALL: shift_output_n  in  16  shifter result.
REQ-009 SHALL: write_address_n  in  4  destination register.
REQ-010 SHALL: data_memory_write_n  in  16  store data.
REQ-011 SHALL: dmem_req  out  1; dmem_we  out  1; dmem_addr  out  16; dmem_wdata  out  16  data-memory request bus.
REQ-012 SHALL: dmem_rdata  in  16; dmem_ack  in  1  data-memory response; ack is a single-cycle pulse.
REQ-013 SHALL: stall  out  1  freeze request to IF/ID/EX and to the EX/MEM register.
REQ-014 SHALL: RegWrite_wb  out  1; write_address_wb  out  4; write_data_wb  out  16  MEM/WB register outputs.
REQ-015 SHALL: mem_err  out  1  sticky memory-timeout flag.
REQ-016 SHALL: TIMEOUT parameter, default 15, is the maximum number of WAIT cycles without ack.

Function
REQ-017 SHALL: FSM states are IDLE and WAIT.
REQ-018 SHALL: an instruction with mem_read_n=0 and mem_write_n=0 in IDLE updates the MEM/WB outputs at the next edge (1-cycle latency) with stall=0.
REQ-019 SHALL: in IDLE with mem_read_n or mem_write_n =1: stall=1 combinationally; address, store data, we, RegWrite, write_address and write_back are latched; next state is WAIT; the MEM/WB outputs take a bubble (RegWrite_wb=0).
REQ-020 SHALL: in WAIT: dmem_req=1 and dmem_addr/dmem_wdata/dmem_we driven from latches and held stable until ack; stall=1 unless dmem_ack=1.
REQ-021 SHALL: WAIT with dmem_ack=1: stall=0 that cycle, dmem_rdata is used for write-back, the MEM/WB outputs update at the edge, and next state is IDLE. Minimum memory-op latency is 2 cycles.
REQ-022 SHALL: when mem_read_n=mem_write_n=1, the access is a write (dmem_we=1), with no rdata capture.
REQ-023 SHALL: write_data_wb is selected by the latched write_back code; code 01 with no read yields 0x0000.
REQ-024 SHALL: dmem_ack in IDLE is ignored.
REQ-025 SHALL: a 4-bit wait counter clears on entry to WAIT and increments each WAIT cycle without ack; when it reaches TIMEOUT, the FSM aborts to IDLE, sets mem_err=1, commits a bubble (RegWrite_wb=0) and deasserts stall that cycle.
REQ-026 SHALL: mem_err stays set until reset.
REQ-027 SHALL: dmem_req=0 in IDLE; dmem_we=0 whenever dmem_req=0.

Reset
REQ-028 SHALL: reset forces state IDLE, counter 0, all latches 0, RegWrite_wb=0, write_address_wb=0, write_data_wb=0x0000, mem_err=0, dmem_req=0, stall=0 in the cycle after reset.
REQ-029 SHALL: reset asserted in WAIT abandons the access without setting mem_err; an ack arriving in the following cycle is ignored.

Structure
REQ-030 SHALL: shared package mem_stage_pkg holds the write-back codes (WB_ALU, WB_MEM, WB_SHIFT, WB_LINK), the FSM state encoding and the default timeout.
REQ-031 SHALL: the write-back selection is implemented as the sub-module wb_select_mux (purely combinational, 4:1 x 16).

Verification
REQ-032 SHALL: ALU op, RegWrite=1, wb=00, ALU=0x1234, dest=3 -> next edge RegWrite_wb=1, write_address_wb=3, write_data_wb=0x1234, stall never 1.
REQ-033 SHALL: load addr=0x0040, ack on 3rd WAIT cycle with rdata=0xBEEF, wb=01, dest=5 -> dmem_req high 3 cycles with addr 0x0040 stable; stall high 3 cycles; write_data_wb=0xBEEF.
REQ-034 SHALL: store addr=0x0010, data=0xA5A5, ack on 1st WAIT cycle -> dmem_we=1, dmem_wdata=0xA5A5; 2-cycle latency; RegWrite_wb=0.
REQ-035 SHALL: load with no ack -> after 15 WAIT cycles, stall drops, mem_err=1 and stays 1; the next ALU op commits normally.
REQ-036 SHALL: reset in the 2nd WAIT cycle, ack pulsed the cycle after -> state IDLE, all outputs 0, mem_err=0.
REQ-037 SHALL: link op, wb=11, link_pc=0x0102, dest=14 -> write_data_wb=0x0102; a stray ack in IDLE causes no change.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: write-back select codes,
// FSM state encoding and the default memory timeout.
package mem_stage_pkg;

  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_MEM   = 2'b01;
  localparam logic [1:0] WB_SHIFT = 2'b10;
  localparam logic [1:0] WB_LINK  = 2'b11;

  localparam int DEFAULT_TIMEOUT = 15;
  localparam int WAIT_CNT_W      = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/wb_select_mux.sv
// Combinational 4:1 x 16 write-back data selector.
module wb_select_mux
  import mem_stage_pkg::*;
(
  input  logic [1:0]  sel,
  input  logic [15:0] alu_data,
  input  logic [15:0] mem_data,
  input  logic [15:0] shift_data,
  input  logic [15:0] link_data,
  output logic [15:0] wb_data
);

  always_comb begin
    wb_data = alu_data;
    case (sel)
      WB_ALU:   wb_data = alu_data;
      WB_MEM:   wb_data = mem_data;
      WB_SHIFT: wb_data = shift_data;
      WB_LINK:  wb_data = link_data;
      default:  wb_data = alu_data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues data-memory requests, stalls the front of the
// pipeline while waiting for ack, and drives the MEM/WB register.
module mem_access_unit
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite_n,
  input  logic [15:0] link_pc_n,
  input  logic        mem_read_n,
  input  logic        mem_write_n,
  input  logic [1:0]  write_back_n,
  input  logic [15:0] ALU_output_n,
  input  logic [15:0] shift_output_n,
  input  logic [3:0]  write_address_n,
  input  logic [15:0] data_memory_write_n,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        RegWrite_wb,
  output logic [3:0]  write_address_wb,
  output logic [15:0] write_data_wb,
  output logic        mem_err
);

  localparam logic [WAIT_CNT_W-1:0] CNT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

  mem_state_e            state_reg, state_next;
  logic [WAIT_CNT_W-1:0] cnt_reg, cnt_next;
  logic [15:0]           addr_reg, addr_next;
  logic [15:0]           wdata_reg, wdata_next;
  logic [15:0]           shift_reg, shift_next;
  logic [15:0]           link_reg, link_next;
  logic                  we_reg, we_next;
  logic                  rd_reg, rd_next;
  logic                  regwrite_reg, regwrite_next;
  logic [3:0]            waddr_reg, waddr_next;
  logic [1:0]            wb_reg, wb_next;
  logic                  rw_wb_reg, rw_wb_next;
  logic [3:0]            waddr_wb_reg, waddr_wb_next;
  logic [15:0]           wdata_wb_reg, wdata_wb_next;
  logic                  mem_err_reg, mem_err_next;

  logic                  in_wait;
  logic [1:0]            mux_sel;
  logic [15:0]           mux_alu, mux_mem, mux_shift, mux_link, mux_out;

  // In WAIT the mux works on the latched instruction; in IDLE on the live one.
  assign in_wait   = (state_reg == S_WAIT);
  assign mux_sel   = in_wait ? wb_reg    : write_back_n;
  assign mux_alu   = in_wait ? addr_reg  : ALU_output_n;
  assign mux_shift = in_wait ? shift_reg : shift_output_n;
  assign mux_link  = in_wait ? link_reg  : link_pc_n;
  assign mux_mem   = (in_wait && rd_reg) ? dmem_rdata : 16'h0000;

  wb_select_mux u_wb_select_mux (
    .sel        (mux_sel),
    .alu_data   (mux_alu),
    .mem_data   (mux_mem),
    .shift_data (mux_shift),
    .link_data  (mux_link),
    .wb_data    (mux_out)
  );

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    shift_next    = shift_reg;
    link_next     = link_reg;
    we_next       = we_reg;
    rd_next       = rd_reg;
    regwrite_next = regwrite_reg;
    waddr_next    = waddr_reg;
    wb_next       = wb_reg;
    rw_wb_next    = 1'b0;
    waddr_wb_next = waddr_wb_reg;
    wdata_wb_next = wdata_wb_reg;
    mem_err_next  = mem_err_reg;
    stall         = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (mem_read_n || mem_write_n) begin
          stall         = 1'b1;
          state_next    = S_WAIT;
          cnt_next      = '0;
          addr_next     = ALU_output_n;
          wdata_next    = data_memory_write_n;
          shift_next    = shift_output_n;
          link_next     = link_pc_n;
          we_next       = mem_write_n;
          rd_next       = mem_read_n & ~mem_write_n;
          regwrite_next = RegWrite_n;
          waddr_next    = write_address_n;
          wb_next       = write_back_n;
        end else begin
          rw_wb_next    = RegWrite_n;
          waddr_wb_next = write_address_n;
          wdata_wb_next = mux_out;
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          state_next    = S_IDLE;
          rw_wb_next    = regwrite_reg;
          waddr_wb_next = waddr_reg;
          wdata_wb_next = mux_out;
        end else if (cnt_reg == CNT_LAST) begin
          // Counter would reach TIMEOUT this cycle: abandon the access.
          state_next   = S_IDLE;
          mem_err_next = 1'b1;
        end else begin
          stall    = 1'b1;
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      shift_reg    <= '0;
      link_reg     <= '0;
      we_reg       <= 1'b0;
      rd_reg       <= 1'b0;
      regwrite_reg <= 1'b0;
      waddr_reg    <= '0;
      wb_reg       <= '0;
      rw_wb_reg    <= 1'b0;
      waddr_wb_reg <= '0;
      wdata_wb_reg <= '0;
      mem_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      shift_reg    <= shift_next;
      link_reg     <= link_next;
      we_reg       <= we_next;
      rd_reg       <= rd_next;
      regwrite_reg <= regwrite_next;
      waddr_reg    <= waddr_next;
      wb_reg       <= wb_next;
      rw_wb_reg    <= rw_wb_next;
      waddr_wb_reg <= waddr_wb_next;
      wdata_wb_reg <= wdata_wb_next;
      mem_err_reg  <= mem_err_next;
    end
  end

  assign dmem_req         = in_wait;
  assign dmem_we          = in_wait & we_reg;
  assign dmem_addr        = addr_reg;
  assign dmem_wdata       = wdata_reg;
  assign RegWrite_wb      = rw_wb_reg;
  assign write_address_wb = waddr_wb_reg;
  assign write_data_wb    = wdata_wb_reg;
  assign mem_err          = mem_err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed ops push expected commits
// and memory handshakes; a forked monitor pops and compares them.
module tb_mem_access_unit;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite_n;
  logic [15:0] link_pc_n;
  logic        mem_read_n;
  logic        mem_write_n;
  logic [1:0]  write_back_n;
  logic [15:0] ALU_output_n;
  logic [15:0] shift_output_n;
  logic [3:0]  write_address_n;
  logic [15:0] data_memory_write_n;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_ack;
  logic        stall;
  logic        RegWrite_wb;
  logic [3:0]  write_address_wb;
  logic [15:0] write_data_wb;
  logic        mem_err;

  mem_access_unit #(.TIMEOUT(15)) dut (
    .clk                 (clk),
    .reset               (reset),
    .RegWrite_n          (RegWrite_n),
    .link_pc_n           (link_pc_n),
    .mem_read_n          (mem_read_n),
    .mem_write_n         (mem_write_n),
    .write_back_n        (write_back_n),
    .ALU_output_n        (ALU_output_n),
    .shift_output_n      (shift_output_n),
    .write_address_n     (write_address_n),
    .data_memory_write_n (data_memory_write_n),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_wdata          (dmem_wdata),
    .dmem_rdata          (dmem_rdata),
    .dmem_ack            (dmem_ack),
    .stall               (stall),
    .RegWrite_wb         (RegWrite_wb),
    .write_address_wb    (write_address_wb),
    .write_data_wb       (write_data_wb),
    .mem_err             (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mem_exp_t;

  wb_exp_t  wb_q[$];
  mem_exp_t mem_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic monitor();
    wb_exp_t  we_e;
    mem_exp_t me_e;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        if (RegWrite_wb === 1'b1) begin
          if (wb_q.size() == 0) begin
            check("spurious_commit", {31'b0, RegWrite_wb}, 32'd0);
          end else begin
            we_e = wb_q.pop_front();
            check("wb_addr", {28'b0, write_address_wb}, {28'b0, we_e.addr});
            check("wb_data", {16'b0, write_data_wb}, {16'b0, we_e.data});
            $display("commit r%0d <= 0x%04h", write_address_wb, write_data_wb);
          end
        end
        if (dmem_req === 1'b1 && dmem_ack === 1'b1) begin
          if (mem_q.size() == 0) begin
            check("spurious_handshake", {31'b0, dmem_ack}, 32'd0);
          end else begin
            me_e = mem_q.pop_front();
            check("dmem_we", {31'b0, dmem_we}, {31'b0, me_e.we});
            check("dmem_addr", {16'b0, dmem_addr}, {16'b0, me_e.addr});
            check("dmem_wdata", {16'b0, dmem_wdata}, {16'b0, me_e.wdata});
            $display("mem %s addr=0x%04h wdata=0x%04h", dmem_we ? "wr" : "rd", dmem_addr, dmem_wdata);
          end
        end
      end
    end
  endtask

  task automatic drive_nop();
    RegWrite_n = 1'b0; mem_read_n = 1'b0; mem_write_n = 1'b0;
    write_back_n = WB_ALU; ALU_output_n = '0; shift_output_n = '0;
    link_pc_n = '0; write_address_n = '0; data_memory_write_n = '0;
  endtask

  // Called just after a posedge; returns just after the edge that retires the op.
  task automatic do_op(input string name, input logic rw, input logic mr, input logic mw,
                       input logic [1:0] wb, input logic [15:0] alu, input logic [15:0] shf,
                       input logic [15:0] lpc, input logic [15:0] wdat, input logic [3:0] dest,
                       input int ack_at, input logic [15:0] rdata,
                       output int cycles, output int stalls, output int reqs);
    int widx;
    bit done;
    bit addr_bad;
    widx = 0; done = 1'b0; addr_bad = 1'b0;
    cycles = 0; stalls = 0; reqs = 0;
    RegWrite_n = rw; mem_read_n = mr; mem_write_n = mw; write_back_n = wb;
    ALU_output_n = alu; shift_output_n = shf; link_pc_n = lpc;
    data_memory_write_n = wdat; write_address_n = dest;
    while (!done && cycles < 40) begin
      if (dmem_req === 1'b1) widx++;
      dmem_ack   = (ack_at > 0 && widx == ack_at && dmem_req === 1'b1);
      dmem_rdata = rdata;
      @(negedge clk);
      cycles++;
      if (stall === 1'b1) stalls++;
      if (dmem_req === 1'b1) begin
        reqs++;
        if (dmem_addr !== alu) addr_bad = 1'b1;
      end
      if (stall === 1'b0) done = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
    end
    check({name, "_completed"}, {31'b0, done}, 32'd1);
    check({name, "_addr_stable"}, {31'b0, addr_bad}, 32'd0);
    drive_nop();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, stl, rq;
    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    drive_nop();
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    check("rst_regwrite_wb", {31'b0, RegWrite_wb}, 32'd0);
    check("rst_waddr_wb", {28'b0, write_address_wb}, 32'd0);
    check("rst_wdata_wb", {16'b0, write_data_wb}, 32'd0);
    check("rst_mem_err", {31'b0, mem_err}, 32'd0);
    @(posedge clk); #1;

    // ALU op: single-cycle commit, no stall
    wb_q.push_back('{addr: 4'd3, data: 16'h1234});
    do_op("alu", 1, 0, 0, WB_ALU, 16'h1234, 16'h5555, 16'h0777, 16'h0000, 4'd3, 0, 16'h0, cyc, stl, rq);
    check("alu_cycles", cyc, 1);
    check("alu_stalls", stl, 0);

    // Load, ack on 3rd WAIT cycle
    mem_q.push_back('{we: 1'b0, addr: 16'h0040, wdata: 16'h1111});
    wb_q.push_back('{addr: 4'd5, data: 16'hBEEF});
    do_op("load", 1, 1, 0, WB_MEM, 16'h0040, 16'h0, 16'h0, 16'h1111, 4'd5, 3, 16'hBEEF, cyc, stl, rq);
    check("load_cycles", cyc, 4);
    check("load_stalls", stl, 3);
    check("load_reqs", rq, 3);

    // Store, ack on 1st WAIT cycle: minimum 2-cycle latency, no commit
    mem_q.push_back('{we: 1'b1, addr: 16'h0010, wdata: 16'hA5A5});
    do_op("store", 0, 0, 1, WB_ALU, 16'h0010, 16'h0, 16'h0, 16'hA5A5, 4'd2, 1, 16'h0, cyc, stl, rq);
    check("store_cycles", cyc, 2);
    check("store_stalls", stl, 1);
    @(negedge clk);
    check("store_regwrite_wb", {31'b0, RegWrite_wb}, 32'd0);
    @(posedge clk); #1;

    // Shifter result
    wb_q.push_back('{addr: 4'd7, data: 16'hC3C3});
    do_op("shift", 1, 0, 0, WB_SHIFT, 16'h0F0F, 16'hC3C3, 16'h0, 16'h0, 4'd7, 0, 16'h0, cyc, stl, rq);
    check("shift_cycles", cyc, 1);

    // Read and write both set: treated as a write, rdata not captured
    mem_q.push_back('{we: 1'b1, addr: 16'h0020, wdata: 16'h5A5A});
    wb_q.push_back('{addr: 4'd9, data: 16'h0000});
    do_op("rdwr", 1, 1, 1, WB_MEM, 16'h0020, 16'h0, 16'h0, 16'h5A5A, 4'd9, 2, 16'h7777, cyc, stl, rq);
    check("rdwr_cycles", cyc, 3);

    // Memory select without a memory op yields zero
    wb_q.push_back('{addr: 4'd4, data: 16'h0000});
    do_op("memsel_noop", 1, 0, 0, WB_MEM, 16'h9999, 16'h0, 16'h0, 16'h0, 4'd4, 0, 16'h4321, cyc, stl, rq);

    // Link op, then a stray ack in IDLE
    wb_q.push_back('{addr: 4'd14, data: 16'h0102});
    do_op("link", 1, 0, 0, WB_LINK, 16'h0, 16'h0, 16'h0102, 16'h0, 4'd14, 0, 16'h0, cyc, stl, rq);
    dmem_ack = 1'b1; dmem_rdata = 16'hFFFF;
    @(negedge clk);
    check("stray_ack_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_req", {31'b0, dmem_req}, 32'd0);
    check("stray_ack_regwrite", {31'b0, RegWrite_wb}, 32'd0);
    @(posedge clk); #1;

    // Load with no ack: timeout abort
    do_op("timeout", 1, 1, 0, WB_MEM, 16'h0080, 16'h0, 16'h0, 16'h0, 4'd6, 0, 16'h0, cyc, stl, rq);
    check("timeout_cycles", cyc, 16);
    check("timeout_stalls", stl, 15);
    check("timeout_reqs", rq, 15);
    @(negedge clk);
    check("timeout_mem_err", {31'b0, mem_err}, 32'd1);
    check("timeout_bubble", {31'b0, RegWrite_wb}, 32'd0);
    @(posedge clk); #1;
    wb_q.push_back('{addr: 4'd1, data: 16'hABCD});
    do_op("after_timeout", 1, 0, 0, WB_ALU, 16'hABCD, 16'h0, 16'h0, 16'h0, 4'd1, 0, 16'h0, cyc, stl, rq);
    @(negedge clk);
    check("mem_err_sticky", {31'b0, mem_err}, 32'd1);
    @(posedge clk); #1;

    // Reset in the 2nd WAIT cycle, ack the cycle after
    RegWrite_n = 1'b1; mem_read_n = 1'b1; write_back_n = WB_MEM;
    ALU_output_n = 16'h0300; write_address_n = 4'd8;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("wait2_req", {31'b0, dmem_req}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    drive_nop();
    dmem_ack = 1'b1; dmem_rdata = 16'hDEAD;
    @(negedge clk);
    check("rstw_req", {31'b0, dmem_req}, 32'd0);
    check("rstw_we", {31'b0, dmem_we}, 32'd0);
    check("rstw_addr", {16'b0, dmem_addr}, 32'd0);
    check("rstw_stall", {31'b0, stall}, 32'd0);
    check("rstw_regwrite_wb", {31'b0, RegWrite_wb}, 32'd0);
    check("rstw_waddr_wb", {28'b0, write_address_wb}, 32'd0);
    check("rstw_wdata_wb", {16'b0, write_data_wb}, 32'd0);
    check("rstw_mem_err", {31'b0, mem_err}, 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check("rstw_ack_ignored_req", {31'b0, dmem_req}, 32'd0);
    check("rstw_ack_ignored_rw", {31'b0, RegWrite_wb}, 32'd0);
    check("rstw_ack_ignored_err", {31'b0, mem_err}, 32'd0);

    repeat (3) @(negedge clk);
    check("wb_queue_drained", wb_q.size(), 0);
    check("mem_queue_drained", mem_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
